if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch pipeline.
- Contains the pre-IF next-PC logic and the IF stage.
- Issues fetch requests on an SRAM-like instruction port (req/addr_ok/data_ok) and buffers the returned instruction until the decode stage accepts it.
- Handles redirects from the decode-stage branch, the writeback-stage exception and ertn, and discards responses for cancelled requests.
- Feeds the decode stage through fs2ds_valid/fs2ds_bus and ds_allowin.

---
 rtl/if_stage.sv | 174 +++++++++++++++++
 tb/tb_if_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// LoongArch instruction-fetch stage: pre-IF next-PC selection plus the IF stage on an SRAM-like port.
// Optional IF_ADEF_EN: misaligned fetch PCs raise ADEF instead of issuing a request.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    output logic        fs2ds_valid,
    output logic [63:0] fs2ds_bus,
    input  logic [32:0] br_zip,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] era,
    output logic        fs_ex_adef,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] nextpc;

    logic        fs_ready_go;
    logic        fs_allowin;
    logic        issue_ok;
    logic        hs;
    logic        accept;
    logic [31:0] inst;

    logic        adef_pc;
    logic        adef_q;
    logic        adef_stop_q;
    logic        adef_load;

    logic [31:0] pc_last_q, pc_last_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_pc_q, rd_pc_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic        discard_q, discard_d;

    assign {br_taken, br_target} = br_zip;
    assign flush = wb_ex | ertn_flush | br_taken;

    always_comb begin
        flush_pc = br_target;
        if (wb_ex) begin
            flush_pc = ex_entry;
        end else if (ertn_flush) begin
            flush_pc = era;
        end
    end

    assign nextpc = flush      ? flush_pc :
                    rd_valid_q ? rd_pc_q  : pc_last_q + 32'd4;

    assign fs_ready_go = buf_valid_q | (inst_sram_data_ok & ~discard_q) | adef_q;
    assign fs_allowin  = ~fs_valid_q | (fs_ready_go & ds_allowin) | flush;
    // After an ADEF entry only a redirect may restart fetching.
    assign issue_ok    = ~reset & fs_allowin & ~discard_q & (~adef_stop_q | flush);
    assign adef_load   = issue_ok & adef_pc;
    assign hs          = inst_sram_req & inst_sram_addr_ok;
    assign accept      = hs | adef_load;

    assign inst_sram_req   = issue_ok & ~adef_pc;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

    always_comb begin
        pc_last_d   = pc_last_q;
        rd_valid_d  = rd_valid_q;
        rd_pc_d     = rd_pc_q;
        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        inst_buf_d  = inst_buf_q;
        buf_valid_d = buf_valid_q;
        discard_d   = discard_q;

        if (accept) begin
            fs_valid_d  = 1'b1;
            fs_pc_d     = nextpc;
            pc_last_d   = nextpc;
            buf_valid_d = 1'b0;
            rd_valid_d  = 1'b0;
        end else begin
            if (flush) begin
                rd_valid_d = 1'b1;
                rd_pc_d    = flush_pc;
            end
            if (fs_valid_q & (flush | (fs_ready_go & ds_allowin))) begin
                fs_valid_d  = 1'b0;
                buf_valid_d = 1'b0;
            end else if (fs_valid_q & inst_sram_data_ok & ~discard_q & ~ds_allowin) begin
                inst_buf_d  = inst_sram_rdata;
                buf_valid_d = 1'b1;
            end
        end

        // Set wins: a stale response may drain in the same cycle a live one is cancelled.
        if (flush & fs_valid_q & ~fs_ready_go) begin
            discard_d = 1'b1;
        end else if (inst_sram_data_ok & discard_q) begin
            discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_last_q   <= RESET_PC - 32'd4;
            rd_valid_q  <= 1'b0;
            rd_pc_q     <= 32'd0;
            fs_valid_q  <= 1'b0;
            fs_pc_q     <= 32'd0;
            inst_buf_q  <= 32'd0;
            buf_valid_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            pc_last_q   <= pc_last_d;
            rd_valid_q  <= rd_valid_d;
            rd_pc_q     <= rd_pc_d;
            fs_valid_q  <= fs_valid_d;
            fs_pc_q     <= fs_pc_d;
            inst_buf_q  <= inst_buf_d;
            buf_valid_q <= buf_valid_d;
            discard_q   <= discard_d;
        end
    end

`ifdef IF_ADEF_EN
    assign adef_pc = |nextpc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            adef_q      <= 1'b0;
            adef_stop_q <= 1'b0;
        end else begin
            adef_q <= accept ? adef_load : (adef_q & fs_valid_d);
            if (adef_load) begin
                adef_stop_q <= 1'b1;
            end else if (flush) begin
                adef_stop_q <= 1'b0;
            end
        end
    end

    assign fs_ex_adef = fs_valid_q & adef_q;
`else
    assign adef_pc     = 1'b0;
    assign adef_q      = 1'b0;
    assign adef_stop_q = 1'b0;
    assign fs_ex_adef  = 1'b0;
`endif

    assign inst        = adef_q ? 32'd0 : (buf_valid_q ? inst_buf_q : inst_sram_rdata);
    assign fs2ds_valid = fs_valid_q & fs_ready_go & ~flush;
    assign fs2ds_bus   = fs2ds_valid ? {fs_pc_q, inst} : 64'd0;

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage: SRAM responder model, program-order expectation queue.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic        fs2ds_valid;
    logic [63:0] fs2ds_bus;
    logic [32:0] br_zip;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] era;
    logic        fs_ex_adef;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .fs2ds_valid       (fs2ds_valid),
        .fs2ds_bus         (fs2ds_bus),
        .br_zip            (br_zip),
        .wb_ex             (wb_ex),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .era               (era),
        .fs_ex_adef        (fs_ex_adef),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned ready;
    } req_t;

    exp_t        exp_q[$];
    req_t        pend_q[$];
    logic [31:0] hs_log[$];
    int unsigned hs_cyc[$];
    int unsigned cyc = 0;
    int unsigned delivered = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned addr_ok_pct = 100;
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h1c00_000c) return 32'h0280_0421;
        return {a[15:0] ^ 16'h5a3c, a[31:16] ^ a[15:0] ^ 16'h0001};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected program order from a fetch target: sequential, or a lone ADEF entry.
    task automatic push_window(input logic [31:0] tgt);
        exp_t e;
        exp_q.delete();
        if (tgt[1:0] != 2'b00) begin
            e.pc = tgt; e.inst = 32'd0; e.adef = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < 256; i++) begin
                e.pc = tgt + 32'(4 * i); e.inst = mem(e.pc); e.adef = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic ex, input logic ertn, input logic br,
                            input logic [31:0] t_ex, input logic [31:0] t_era,
                            input logic [31:0] t_br);
        logic [31:0] tgt;
        tgt = ex ? t_ex : (ertn ? t_era : t_br);
        wb_ex = ex; ex_entry = t_ex; ertn_flush = ertn; era = t_era; br_zip = {br, t_br};
        push_window(tgt);
        #1;
        check("redirect_addr", {32'd0, inst_sram_addr}, {32'd0, tgt});
        tick();
        wb_ex = 1'b0; ertn_flush = 1'b0; br_zip = 33'd0;
    endtask

    task automatic wait_hs(input int n, input string name);
        for (int i = 0; i < 60 && hs_log.size() < n; i++) tick();
        check(name, 64'(hs_log.size() >= n), 64'd1);
    endtask

    // SRAM responder: in-order, programmable accept rate and read latency.
    initial begin
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            inst_sram_addr_ok = ($urandom_range(99) < addr_ok_pct);
            if (pend_q.size() > 0 && cyc >= pend_q[0].ready) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = mem(pend_q[0].addr);
            end else begin
                inst_sram_data_ok = 1'b0;
                inst_sram_rdata   = $urandom;
            end
        end
    end

    // Monitor: tracks the SRAM queue and pops the scoreboard on each decode acceptance.
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        logic flush_now;
        if (!reset) begin
            flush_now = wb_ex | ertn_flush | br_zip[32];
            if (inst_sram_data_ok && pend_q.size() > 0) void'(pend_q.pop_front());
            if (inst_sram_req && inst_sram_addr_ok) begin
                r.addr  = inst_sram_addr;
                r.ready = cyc + 1 + $urandom_range(lat_max, lat_min);
                pend_q.push_back(r);
                hs_log.push_back(inst_sram_addr);
                hs_cyc.push_back(cyc);
            end
            if (prev_stall && inst_sram_req && !flush_now)
                check("addr_hold", {32'd0, inst_sram_addr}, {32'd0, prev_addr});
            prev_stall = inst_sram_req && !inst_sram_addr_ok;
            prev_addr  = inst_sram_addr;
            if (fs2ds_valid) begin
                if (ds_allowin) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_delivery", fs2ds_bus, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliver_pc", {32'd0, fs2ds_bus[63:32]}, {32'd0, e.pc});
                        check("deliver_inst", {32'd0, fs2ds_bus[31:0]}, {32'd0, e.inst});
                        check("deliver_adef", {63'd0, fs_ex_adef}, {63'd0, e.adef});
                    end
                    delivered++;
                end
            end else begin
                check("bus_idle", fs2ds_bus, 64'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int unsigned idx;
        int unsigned d0;
        int unsigned kind;
        reset = 1'b1; ds_allowin = 1'b1; br_zip = 33'd0; wb_ex = 1'b0; ertn_flush = 1'b0;
        ex_entry = 32'h1c00_7000; era = 32'h1c00_6000;
        repeat (3) tick();
        check("rst_req", {63'd0, inst_sram_req}, 64'd0);
        check("rst_valid", {63'd0, fs2ds_valid}, 64'd0);
        check("rst_bus", fs2ds_bus, 64'd0);
        check("rst_adef", {63'd0, fs_ex_adef}, 64'd0);
        check("const_port", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
              {25'd0, 1'b0, 2'b10, 4'd0, 32'd0});

        // Full-speed sequential fetch straight out of reset.
        reset = 1'b0;
        push_window(32'h1c00_0000);
        #1;
        check("first_req", {63'd0, inst_sram_req}, 64'd1);
        check("first_addr", {32'd0, inst_sram_addr}, 64'h1c00_0000);
        wait_hs(3, "seq_hs_timeout");
        if (hs_log.size() >= 3) begin
            check("seq_addr0", {32'd0, hs_log[0]}, 64'h1c00_0000);
            check("seq_addr1", {32'd0, hs_log[1]}, 64'h1c00_0004);
            check("seq_addr2", {32'd0, hs_log[2]}, 64'h1c00_0008);
            check("seq_b2b", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);
        end

        // Decode stall while 1c00000c returns: held in the buffer, no new request.
        for (int i = 0; i < 20 && delivered < 3; i++) tick();
        ds_allowin = 1'b0;
        #1;
        check("stall_req", {63'd0, inst_sram_req}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req", {63'd0, inst_sram_req}, 64'd0);
            check("stall_valid", {63'd0, fs2ds_valid}, 64'd1);
            check("stall_bus", fs2ds_bus, {32'h1c00_000c, 32'h0280_0421});
        end
        d0 = delivered;
        ds_allowin = 1'b1;
        tick();
        check("stall_release", 64'(delivered - d0), 64'd1);

        // Branch while a slow request is in flight.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 40; i++) begin
            if (pend_q.size() == 1 && !inst_sram_data_ok && cyc > hs_cyc[hs_cyc.size() - 1]) break;
            tick();
        end
        idx = hs_log.size();
        d0  = delivered;
        redirect(1'b0, 1'b0, 1'b1, 32'h1c00_7000, 32'h1c00_6000, 32'h1c00_0100);
        wait_hs(idx + 1, "br_hs_timeout");
        if (hs_log.size() > idx) check("br_addr", {32'd0, hs_log[idx]}, 64'h1c00_0100);
        for (int i = 0; i < 30 && delivered == d0; i++) tick();
        check("br_delivered", 64'(delivered > d0), 64'd1);

        // Exception beats a simultaneous branch.
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 20 && pend_q.size() > 1; i++) tick();
        idx = hs_log.size();
        redirect(1'b1, 1'b0, 1'b1, 32'h1c00_8000, 32'h1c00_6000, 32'h1c00_0300);
        wait_hs(idx + 1, "ex_hs_timeout");
        if (hs_log.size() > idx) check("ex_addr", {32'd0, hs_log[idx]}, 64'h1c00_8000);

        // ertn redirect while the SRAM refuses addresses.
        addr_ok_pct = 0;
        repeat (8) tick();
        check("idle_req", {63'd0, inst_sram_req}, 64'd1);
        idx = hs_log.size();
        redirect(1'b0, 1'b1, 1'b0, 32'h1c00_7000, 32'h1c00_0040, 32'h1c00_0500);
        check("era_hold_req", {63'd0, inst_sram_req}, 64'd1);
        check("era_hold_addr", {32'd0, inst_sram_addr}, 64'h1c00_0040);
        tick();
        check("era_hold_addr", {32'd0, inst_sram_addr}, 64'h1c00_0040);
        addr_ok_pct = 100;
        wait_hs(idx + 2, "era_hs_timeout");
        if (hs_log.size() >= idx + 2) begin
            check("era_addr", {32'd0, hs_log[idx]}, 64'h1c00_0040);
            check("era_next", {32'd0, hs_log[idx + 1]}, 64'h1c00_0044);
        end

`ifdef IF_ADEF_EN
        // Misaligned branch target: ADEF entry, no request, fetch stops.
        for (int i = 0; i < 20 && pend_q.size() > 1; i++) tick();
        d0 = delivered;
        redirect(1'b0, 1'b0, 1'b1, 32'h1c00_7000, 32'h1c00_6000, 32'h1c00_0102);
        idx = hs_log.size();
        for (int i = 0; i < 20 && delivered == d0; i++) tick();
        check("adef_delivered", 64'(delivered - d0), 64'd1);
        repeat (6) tick();
        check("adef_no_req", 64'(hs_log.size()), 64'(idx));
        for (int i = 0; i < 20 && pend_q.size() > 0; i++) tick();
        redirect(1'b0, 1'b0, 1'b1, 32'h1c00_7000, 32'h1c00_6000, 32'h1c00_0200);
`endif

        // Randomised traffic, decode back-pressure and redirects.
        addr_ok_pct = 70; lat_min = 0; lat_max = 3;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            ds_allowin = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 6 && pend_q.size() <= 1) begin
                kind = $urandom_range(7, 1);
                redirect(kind[2], kind[1], kind[0],
                         {16'h1c00, 14'($urandom_range(16383)), 2'b00},
                         {16'h1c00, 14'($urandom_range(16383)), 2'b00},
                         {16'h1c00, 14'($urandom_range(16383)), 2'b00});
            end else begin
                tick();
            end
        end
        ds_allowin = 1'b1; addr_ok_pct = 100;
        repeat (20) tick();
        check("random_progress", 64'(delivered - d0 > 300), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
